// File: rtl/muldiv_issue_queue_pkg.sv
// Shared types and helpers for the mul/div reservation station.
//   - XLEN_WIDTH / PRF_WIDTH / ROB_WIDTH : datapath, physical register and ROB index widths
//   - alu_op_type                        : operation encoding shared with the execution units
//   - muldiv_rs_entry_t                  : one reservation station entry
//   - rob_is_older / rob_is_younger      : ROB age compares using the wrap bit
package muldiv_issue_queue_pkg;

    localparam int XLEN_WIDTH      = 32;
    localparam int PRF_WIDTH       = 6;
    localparam int ROB_WIDTH       = 4;
    localparam int MULDIV_RS_DEPTH = 4;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_type;

    typedef struct packed {
        logic                  valid;
        alu_op_type            op;
        logic [ROB_WIDTH:0]    rob_id;
        logic [PRF_WIDTH-1:0]  prf_id;
        logic [PRF_WIDTH-1:0]  src1_tag;
        logic                  src1_rdy;
        logic [XLEN_WIDTH-1:0] src1_data;
        logic [PRF_WIDTH-1:0]  src2_tag;
        logic                  src2_rdy;
        logic [XLEN_WIDTH-1:0] src2_data;
    } muldiv_rs_entry_t;

    // a is older than b. The MSB is the ROB wrap bit: with equal wrap bits the
    // smaller index is older, otherwise the larger index is older.
    function automatic logic rob_is_older(input logic [ROB_WIDTH:0] a,
                                          input logic [ROB_WIDTH:0] b);
        if (a[ROB_WIDTH] == b[ROB_WIDTH])
            return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
        else
            return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
    endfunction

    // a is strictly younger than the flushing branch f.
    function automatic logic rob_is_younger(input logic [ROB_WIDTH:0] a,
                                            input logic [ROB_WIDTH:0] f);
        return a[ROB_WIDTH] ^ f[ROB_WIDTH] ^ (a[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/muldiv_issue_queue_age_select.sv
// Combinational oldest-ready picker.
//   cand_i   : per-entry candidate bits (valid and both sources ready)
//   rob_id_i : per-entry ROB ids (with wrap bit)
//   found_o  : at least one candidate
//   idx_o    : index of the oldest candidate (0 when none)
module muldiv_age_select
    import muldiv_issue_queue_pkg::*;
#(
    parameter int DEPTH = MULDIV_RS_DEPTH
) (
    input  logic [DEPTH-1:0]                cand_i,
    input  logic [DEPTH-1:0][ROB_WIDTH:0]   rob_id_i,
    output logic                            found_o,
    output logic [$clog2(DEPTH)-1:0]        idx_o
);
    localparam int IDXW = $clog2(DEPTH);

    logic            found;
    logic [IDXW-1:0] idx;

    // Linear scan; ROB ids of live entries are unique so no tie-break is needed.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand_i[i] && (!found || rob_is_older(rob_id_i[i], rob_id_i[idx]))) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

    assign found_o = found;
    assign idx_o   = idx;

endmodule

// File: rtl/muldiv_issue_queue.sv
// Reservation station in front of the mul/div unit.
//   clk, reset_n            : clock, async active-low reset
//   disp_*                  : dispatch handshake and micro-op fields
//   wb_valid/prf_id/data    : CDB wakeup ports
//   flush_valid/flush_robid : squash entries younger than flush_robid
//   md_busy / md_start      : start/busy handshake with the unit
//   md_*                    : issued operation, operands, ROB id and destination
//   count                   : occupied entries
module muldiv_issue_queue
    import muldiv_issue_queue_pkg::*;
#(
    parameter int DEPTH    = MULDIV_RS_DEPTH,
    parameter int WB_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 disp_valid,
    output logic                                 disp_ready,
    input  alu_op_type                           disp_op,
    input  logic [ROB_WIDTH:0]                   disp_rob_id,
    input  logic [PRF_WIDTH-1:0]                 disp_prf_id,
    input  logic [PRF_WIDTH-1:0]                 disp_src1_tag,
    input  logic [PRF_WIDTH-1:0]                 disp_src2_tag,
    input  logic                                 disp_src1_rdy,
    input  logic                                 disp_src2_rdy,
    input  logic [XLEN_WIDTH-1:0]                disp_src1_data,
    input  logic [XLEN_WIDTH-1:0]                disp_src2_data,
    input  logic [WB_PORTS-1:0]                  wb_valid,
    input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0]   wb_prf_id,
    input  logic [WB_PORTS-1:0][XLEN_WIDTH-1:0]  wb_data,
    input  logic                                 flush_valid,
    input  logic [ROB_WIDTH:0]                   flush_robid,
    input  logic                                 md_busy,
    output logic                                 md_start,
    output alu_op_type                           md_operation,
    output logic [XLEN_WIDTH-1:0]                md_left_operand,
    output logic [XLEN_WIDTH-1:0]                md_right_operand,
    output logic [ROB_WIDTH:0]                   md_rob_id,
    output logic [PRF_WIDTH-1:0]                 md_prf_id,
    output logic [$clog2(DEPTH):0]               count
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = IDXW + 1;

    muldiv_rs_entry_t ent_q [DEPTH];
    muldiv_rs_entry_t ent_d [DEPTH];
    muldiv_rs_entry_t new_ent;
    muldiv_rs_entry_t sel_ent;
    logic [CNTW-1:0]  count_q, count_d;
    logic             issued_q;

    logic [DEPTH-1:0]              cand;
    logic [DEPTH-1:0][ROB_WIDTH:0] rob_vec;
    logic                          cand_found;
    logic [IDXW-1:0]               sel_idx;
    logic                          free_found;
    logic [IDXW-1:0]               free_idx;
    logic                          disp_acc;

    // Only registered ready bits count, so a wakeup issues one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i]    = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
            rob_vec[i] = ent_q[i].rob_id;
        end
    end

    muldiv_age_select #(.DEPTH(DEPTH)) u_age_select (
        .cand_i   (cand),
        .rob_id_i (rob_vec),
        .found_o  (cand_found),
        .idx_o    (sel_idx)
    );

    assign sel_ent  = ent_q[sel_idx];
    // issued_q covers the cycle before the unit raises busy.
    assign md_start = cand_found & ~md_busy & ~issued_q & ~flush_valid;

    always_comb begin
        md_operation     = ALU_ADD;
        md_left_operand  = '0;
        md_right_operand = '0;
        md_rob_id        = '0;
        md_prf_id        = '0;
        if (cand_found) begin
            md_operation     = sel_ent.op;
            md_left_operand  = sel_ent.src1_data;
            md_right_operand = sel_ent.src2_data;
            md_rob_id        = sel_ent.rob_id;
            md_prf_id        = sel_ent.prf_id;
        end
    end

    assign disp_ready = (count_q != CNTW'(DEPTH));
    assign count      = count_q;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign disp_acc = disp_valid & disp_ready & free_found & ~flush_valid;

    // Incoming entry, with same-cycle CDB bypass. Ports are scanned high to
    // low so the lowest matching port is the last writer.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.op        = disp_op;
        new_ent.rob_id    = disp_rob_id;
        new_ent.prf_id    = disp_prf_id;
        new_ent.src1_tag  = disp_src1_tag;
        new_ent.src1_rdy  = disp_src1_rdy;
        new_ent.src1_data = disp_src1_data;
        new_ent.src2_tag  = disp_src2_tag;
        new_ent.src2_rdy  = disp_src2_rdy;
        new_ent.src2_data = disp_src2_data;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (!disp_src1_rdy && wb_valid[p] && wb_prf_id[p] == disp_src1_tag) begin
                new_ent.src1_rdy  = 1'b1;
                new_ent.src1_data = wb_data[p];
            end
            if (!disp_src2_rdy && wb_valid[p] && wb_prf_id[p] == disp_src2_tag) begin
                new_ent.src2_rdy  = 1'b1;
                new_ent.src2_data = wb_data[p];
            end
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (ent_q[i].valid && !ent_q[i].src1_rdy && wb_valid[p] &&
                    wb_prf_id[p] == ent_q[i].src1_tag) begin
                    ent_d[i].src1_rdy  = 1'b1;
                    ent_d[i].src1_data = wb_data[p];
                end
                if (ent_q[i].valid && !ent_q[i].src2_rdy && wb_valid[p] &&
                    wb_prf_id[p] == ent_q[i].src2_tag) begin
                    ent_d[i].src2_rdy  = 1'b1;
                    ent_d[i].src2_data = wb_data[p];
                end
            end
            if (flush_valid && ent_q[i].valid && rob_is_younger(ent_q[i].rob_id, flush_robid))
                ent_d[i].valid = 1'b0;
            if (md_start && sel_idx == IDXW'(i))
                ent_d[i].valid = 1'b0;
            // The free slot is never the issuing one, so this cannot collide.
            if (disp_acc && free_idx == IDXW'(i))
                ent_d[i] = new_ent;
        end
    end

    // Occupancy of the next state equals count + dispatched - issued - flushed.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + CNTW'(ent_d[i].valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            count_q  <= '0;
            issued_q <= 1'b0;
        end else begin
            ent_q    <= ent_d;
            count_q  <= count_d;
            issued_q <= md_start;
        end
    end

endmodule

// File: tb/tb_muldiv_issue_queue.sv
// Directed plus randomized bench for muldiv_issue_queue. A queue-of-records
// model tracks live micro-ops; ROB age is judged by modular distance.
module tb_muldiv_issue_queue;
    import muldiv_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WBP   = 2;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic                          disp_valid, disp_ready;
    alu_op_type                    disp_op;
    logic [ROB_WIDTH:0]            disp_rob_id;
    logic [PRF_WIDTH-1:0]          disp_prf_id, disp_src1_tag, disp_src2_tag;
    logic                          disp_src1_rdy, disp_src2_rdy;
    logic [XLEN_WIDTH-1:0]         disp_src1_data, disp_src2_data;
    logic [WBP-1:0]                wb_valid;
    logic [WBP-1:0][PRF_WIDTH-1:0] wb_prf_id;
    logic [WBP-1:0][XLEN_WIDTH-1:0] wb_data;
    logic                          flush_valid;
    logic [ROB_WIDTH:0]            flush_robid;
    logic                          md_busy, md_start;
    alu_op_type                    md_operation;
    logic [XLEN_WIDTH-1:0]         md_left_operand, md_right_operand;
    logic [ROB_WIDTH:0]            md_rob_id;
    logic [PRF_WIDTH-1:0]          md_prf_id;
    logic [$clog2(DEPTH):0]        count;

    always #5 clk = ~clk;

    muldiv_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WBP)) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rob_id(disp_rob_id), .disp_prf_id(disp_prf_id),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
        .wb_valid(wb_valid), .wb_prf_id(wb_prf_id), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .md_busy(md_busy), .md_start(md_start), .md_operation(md_operation),
        .md_left_operand(md_left_operand), .md_right_operand(md_right_operand),
        .md_rob_id(md_rob_id), .md_prf_id(md_prf_id), .count(count)
    );

    typedef struct {
        alu_op_type           op;
        logic [ROB_WIDTH:0]   rob;
        logic [PRF_WIDTH-1:0] prf, t1, t2;
        bit                   r1, r2;
        logic [31:0]          d1, d2;
    } ment_t;

    ment_t              mq[$];
    bit                 m_issued;
    int                 tests = 0, fails = 0;
    bit                 last_start;
    logic [ROB_WIDTH:0] last_rob;
    logic [ROB_WIDTH:0] next_rob;
    logic [ROB_WIDTH:0] got[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // a older than b when (a - b) is negative modulo the ROB id space
    function automatic bit older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
        logic [ROB_WIDTH:0] d;
        d = a - b;
        return d[ROB_WIDTH];
    endfunction

    function automatic bit younger(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] f);
        logic [ROB_WIDTH:0] d;
        d = a - f;
        return (d != 0) && !d[ROB_WIDTH];
    endfunction

    function automatic int wbhit(input logic [PRF_WIDTH-1:0] tag);
        for (int p = 0; p < WBP; p++)
            if (wb_valid[p] && wb_prf_id[p] == tag) return p;
        return -1;
    endfunction

    task automatic idle();
        disp_valid = 0; disp_op = ALU_ADD; disp_rob_id = '0; disp_prf_id = '0;
        disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        disp_src1_data = '0; disp_src2_data = '0;
        wb_valid = '0; wb_prf_id = '0; wb_data = '0;
        flush_valid = 0; flush_robid = '0;
    endtask

    task automatic disp(input alu_op_type op, input logic [ROB_WIDTH:0] rob,
                        input logic [PRF_WIDTH-1:0] prf,
                        input logic [PRF_WIDTH-1:0] t1, input bit r1, input logic [31:0] d1,
                        input logic [PRF_WIDTH-1:0] t2, input bit r2, input logic [31:0] d2);
        disp_valid = 1; disp_op = op; disp_rob_id = rob; disp_prf_id = prf;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src1_data = d1;
        disp_src2_tag = t2; disp_src2_rdy = r2; disp_src2_data = d2;
    endtask

    // Called just after a negedge with inputs driven: checks outputs against
    // the model, then advances the model across the next posedge.
    task automatic step();
        bit    found, es, acc;
        int    si, p;
        ment_t n;
        #1;
        found = 0; si = 0;
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].r1 && mq[k].r2 && (!found || older(mq[k].rob, mq[si].rob))) begin
                found = 1; si = k;
            end
        es = found && !md_busy && !m_issued && !flush_valid;
        chk("md_start", md_start, es);
        chk("disp_ready", disp_ready, mq.size() != DEPTH);
        chk("count", count, mq.size());
        if (found)
            chk("md_fields", {md_operation, md_left_operand, md_right_operand, md_rob_id, md_prf_id},
                {mq[si].op, mq[si].d1, mq[si].d2, mq[si].rob, mq[si].prf});
        else
            chk("md_idle", {md_operation, md_left_operand, md_right_operand, md_rob_id, md_prf_id},
                {ALU_ADD, 32'd0, 32'd0, 5'd0, 6'd0});
        last_start = md_start;
        last_rob   = md_rob_id;
        acc = disp_valid && mq.size() < DEPTH && !flush_valid;
        @(posedge clk);
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].r1) begin p = wbhit(mq[k].t1); if (p >= 0) begin mq[k].r1 = 1; mq[k].d1 = wb_data[p]; end end
            if (!mq[k].r2) begin p = wbhit(mq[k].t2); if (p >= 0) begin mq[k].r2 = 1; mq[k].d2 = wb_data[p]; end end
        end
        if (flush_valid) begin
            for (int k = mq.size() - 1; k >= 0; k--)
                if (younger(mq[k].rob, flush_robid)) mq.delete(k);
        end else if (es) begin
            mq.delete(si);
        end
        if (acc) begin
            n.op = disp_op; n.rob = disp_rob_id; n.prf = disp_prf_id;
            n.t1 = disp_src1_tag; n.r1 = disp_src1_rdy; n.d1 = disp_src1_data;
            n.t2 = disp_src2_tag; n.r2 = disp_src2_rdy; n.d2 = disp_src2_data;
            if (!n.r1) begin p = wbhit(n.t1); if (p >= 0) begin n.r1 = 1; n.d1 = wb_data[p]; end end
            if (!n.r2) begin p = wbhit(n.t2); if (p >= 0) begin n.r2 = 1; n.d2 = wb_data[p]; end end
            mq.push_back(n);
        end
        m_issued = es;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset_n = 0; md_busy = 0; idle();
        m_issued = 0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", disp_ready, 1);
        chk("rst_start", md_start, 0);
        chk("rst_op", md_operation, ALU_ADD);
        reset_n = 1;
        @(negedge clk);

        // 1: ready MUL issues on the following cycle
        disp(ALU_MUL, 5'd3, 6'd10, 6'd1, 1, 32'd7, 6'd2, 1, 32'd6);
        step(); idle(); #1;
        chk("t1_start", md_start, 1);
        chk("t1_ops", {md_operation, md_left_operand, md_right_operand}, {ALU_MUL, 32'd7, 32'd6});
        chk("t1_ids", {md_rob_id, md_prf_id}, {5'd3, 6'd10});
        chk("t1_count1", count, 1);
        step(); #1;
        chk("t1_count0", count, 0);

        // 2: wakeup on port 1, issue exactly one cycle later
        disp(ALU_DIV, 5'd5, 6'd11, 6'd20, 0, 32'd0, 6'd21, 1, 32'd3);
        step(); idle(); step();
        wb_valid = 2'b10; wb_prf_id[1] = 6'd20; wb_data[1] = 32'd100;
        #1 chk("t2_no_early", md_start, 0);
        step(); idle(); #1;
        chk("t2_start", md_start, 1);
        chk("t2_left", md_left_operand, 100);
        step(); step();

        // 3: fill while busy, overflow dispatch ignored, drain in age order
        md_busy = 1;
        disp(ALU_MUL,  5'd6, 6'd1, 6'd0, 1, 32'd60, 6'd0, 1, 32'd61); step();
        disp(ALU_DIVU, 5'd4, 6'd2, 6'd0, 1, 32'd40, 6'd0, 1, 32'd41); step();
        disp(ALU_REM,  5'd7, 6'd3, 6'd0, 1, 32'd70, 6'd0, 1, 32'd71); step();
        disp(ALU_REMU, 5'd5, 6'd4, 6'd0, 1, 32'd50, 6'd0, 1, 32'd51); step();
        disp(ALU_MUL,  5'd8, 6'd5, 6'd0, 1, 32'd80, 6'd0, 1, 32'd81);
        #1 chk("t3_full", disp_ready, 0);
        step(); idle(); #1;
        chk("t3_count", count, 4);
        md_busy = 0;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            step();
            if (last_start) got.push_back(last_rob);
        end
        chk("t3_issued", got.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("t3_order", (k < got.size()) ? got[k] : 5'h1f, 5'(4 + k));

        // 4: flush at 15 removes only the wrapped rob 0
        md_busy = 1;
        disp(ALU_MUL, 5'd14, 6'd6, 6'd0, 1, 32'd1, 6'd0, 1, 32'd2); step();
        disp(ALU_DIV, 5'd15, 6'd7, 6'd0, 1, 32'd3, 6'd0, 1, 32'd4); step();
        disp(ALU_REM, 5'd16, 6'd8, 6'd0, 1, 32'd5, 6'd0, 1, 32'd6); step();
        idle(); md_busy = 0; flush_valid = 1; flush_robid = 5'd15;
        #1 chk("t4_count3", count, 3);
        chk("t4_no_start", md_start, 0);
        step(); idle(); #1;
        chk("t4_count2", count, 2);
        for (int c = 0; c < 6; c++) step();

        // 5: dispatch during flush is dropped
        flush_valid = 1; flush_robid = 5'd20;
        disp(ALU_MUL, 5'd21, 6'd9, 6'd0, 1, 32'd9, 6'd0, 1, 32'd9);
        step(); idle(); #1;
        chk("t5_count", count, 0);

        // 6: async reset mid-cycle clears state immediately
        md_busy = 1;
        disp(ALU_MUL,  5'd21, 6'd1, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1); step();
        disp(ALU_DIV,  5'd22, 6'd2, 6'd0, 1, 32'd2, 6'd0, 1, 32'd2); step();
        disp(ALU_DIVU, 5'd23, 6'd3, 6'd0, 1, 32'd3, 6'd0, 1, 32'd3); step();
        idle(); md_busy = 0;
        #1 chk("t6_pre_start", md_start, 1);
        chk("t6_pre_count", count, 3);
        #1 reset_n = 0;
        #1 chk("t6_count", count, 0);
        chk("t6_start", md_start, 0);
        chk("t6_ready", disp_ready, 1);
        mq.delete(); m_issued = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // Randomized traffic against the model
        next_rob = 5'd0;
        for (int c = 0; c < 400; c++) begin
            idle();
            md_busy = ($urandom % 3) == 0;
            for (int p = 0; p < WBP; p++) begin
                wb_valid[p]  = $urandom % 2;
                wb_prf_id[p] = 6'($urandom_range(0, 7));
                wb_data[p]   = $urandom;
            end
            if (($urandom % 16) == 0) begin
                flush_valid = 1;
                flush_robid = next_rob - 5'd1 - 5'($urandom_range(0, 3));
            end
            ok = 1;
            foreach (mq[k]) if (5'(next_rob - mq[k].rob) >= 5'd13) ok = 0;
            if (ok && ($urandom % 2))
                disp(alu_op_type'(4'($urandom_range(10, 14))), next_rob, 6'($urandom),
                     6'($urandom_range(0, 7)), $urandom % 2, $urandom,
                     6'($urandom_range(0, 7)), $urandom % 2, $urandom);
            if (flush_valid)
                next_rob = flush_robid + 5'd1;
            else if (disp_valid && mq.size() < DEPTH)
                next_rob = next_rob + 5'd1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
